// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port block RAM between NREQ requesters.
// Writes go straight to port A; reads use port B and return data through a registered per-requester slot.
module bram_arbiter #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned ADDRW = $clog2(DEPTH),
    parameter int unsigned MASKW = WIDTH / 8,
    parameter int unsigned NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*ADDRW-1:0]   req_addr,
    input  logic [NREQ*MASKW-1:0]   req_wmask,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [NREQ*WIDTH-1:0]   resp_data,
    output logic                    bram_ena,
    output logic [MASKW-1:0]        bram_wea,
    output logic [ADDRW-1:0]        bram_addra,
    output logic [WIDTH-1:0]        bram_dia,
    output logic                    bram_enb,
    output logic [ADDRW-1:0]        bram_addrb,
    input  logic [WIDTH-1:0]        bram_dob
);

    localparam int unsigned IDXW = $clog2(NREQ);

    logic [IDXW-1:0]       last_grant_q, last_grant_d;
    logic [NREQ-1:0]       pending_q, pending_d;
    logic [NREQ-1:0]       resp_valid_q, resp_valid_d;
    logic [NREQ*WIDTH-1:0] resp_data_q, resp_data_d;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  grant;
    logic [IDXW-1:0]  grant_idx;
    logic             grant_any;
    logic [IDXW-1:0]  sel;
    logic             sel_we;
    logic [ADDRW-1:0] sel_addr;
    logic [MASKW-1:0] sel_mask;
    logic [WIDTH-1:0] sel_wdata;

    // A read is only eligible once its slot is free or being drained this cycle.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = rst_n & req_valid[i] &
                      (req_we[i] | (~pending_q[i] & (~resp_valid_q[i] | resp_ready[i])));
        end
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_grant_q) + k) % NREQ;
            if (!grant_any && elig[IDXW'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IDXW'(idx);
            end
        end
        grant = grant_any ? (NREQ'(1) << grant_idx) : '0;
    end

    // Idle cycles drive the RAM address/data from requester 0.
    always_comb begin
        sel        = grant_any ? grant_idx : '0;
        sel_we     = req_we[sel];
        sel_addr   = req_addr[32'(sel)*ADDRW +: ADDRW];
        sel_mask   = req_wmask[32'(sel)*MASKW +: MASKW];
        sel_wdata  = req_wdata[32'(sel)*WIDTH +: WIDTH];
        bram_ena   = grant_any & sel_we;
        bram_wea   = bram_ena ? sel_mask : '0;
        bram_addra = sel_addr;
        bram_dia   = sel_wdata;
        bram_enb   = grant_any & ~sel_we;
        bram_addrb = sel_addr;
    end

    // Capture of RAM read data takes priority over a same-edge drain.
    always_comb begin
        last_grant_d = grant_any ? grant_idx : last_grant_q;
        pending_d    = grant & ~req_we;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (resp_valid_q[i] && resp_ready[i]) begin
                resp_valid_d[i] = 1'b0;
            end
            if (pending_q[i]) begin
                resp_valid_d[i]                 = 1'b1;
                resp_data_d[i*WIDTH +: WIDTH]   = bram_dob;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDXW'(NREQ - 1);
            pending_q    <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed, table-driven bench for bram_arbiter with two requesters and a behavioural block RAM.
module tb_bram_arbiter;

    localparam int unsigned WIDTH = 128;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned ADDRW = 7;
    localparam int unsigned MASKW = 16;
    localparam int unsigned NREQ  = 2;

    localparam logic [WIDTH-1:0] ONES = {16{8'h11}};
    localparam logic [WIDTH-1:0] ABW  = {{15{8'h11}}, 8'hAB};
    localparam logic [WIDTH-1:0] XD   = {4{32'hDEADBEEF}};
    localparam logic [WIDTH-1:0] DAB  = 128'hAB;
    localparam logic [WIDTH-1:0] Z    = '0;
    localparam logic [MASKW-1:0] FULL = 16'hFFFF;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid, req_ready, req_we;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*MASKW-1:0] req_wmask;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       resp_valid, resp_ready;
    logic [NREQ*WIDTH-1:0] resp_data;
    logic                  bram_ena, bram_enb;
    logic [MASKW-1:0]      bram_wea;
    logic [ADDRW-1:0]      bram_addra, bram_addrb;
    logic [WIDTH-1:0]      bram_dia, bram_dob;

    int checks = 0;
    int errors = 0;

    bram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW), .MASKW(MASKW), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dia(bram_dia),
        .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_dob(bram_dob)
    );

    always #5 clk = ~clk;

    // Block RAM: byte-masked write port A, registered read port B.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bram_ena) begin
            for (int b = 0; b < int'(MASKW); b++) begin
                if (bram_wea[b]) mem[bram_addra][b*8 +: 8] <= bram_dia[b*8 +: 8];
            end
        end
        if (bram_enb) bram_dob <= mem[bram_addrb];
    end

    typedef struct packed {
        logic [1:0]       vld, we, rr;
        logic [ADDRW-1:0] a0, a1;
        logic [MASKW-1:0] m0;
        logic [WIDTH-1:0] d0;
        logic [1:0]       rdy;
        logic             ena, enb;
        logic [MASKW-1:0] wea;
        logic [1:0]       rv;
        logic [WIDTH-1:0] e0, e1;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] vld, we, rr, input logic [ADDRW-1:0] a0, a1,
                                input logic [MASKW-1:0] m0, input logic [WIDTH-1:0] d0,
                                input logic [1:0] rdy, input logic ena, enb,
                                input logic [MASKW-1:0] wea, input logic [1:0] rv,
                                input logic [WIDTH-1:0] e0, e1);
        vec_t v;
        v.vld = vld; v.we = we; v.rr = rr; v.a0 = a0; v.a1 = a1; v.m0 = m0; v.d0 = d0;
        v.rdy = rdy; v.ena = ena; v.enb = enb; v.wea = wea; v.rv = rv; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic chk(input string nm, input int n, input logic [WIDTH-1:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h exp %h", nm, n, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid  = v.vld;
        req_we     = v.we;
        resp_ready = v.rr;
        req_addr   = {v.a1, v.a0};
        req_wmask  = {v.m0, v.m0};
        req_wdata  = {v.d0, v.d0};
    endtask

    task automatic cyc(input vec_t v);
        @(posedge clk);
        #1 drive(v);
        #1;
    endtask

    task automatic check_vec(input string nm, input int n, input vec_t v);
        chk({nm, ".req_ready"}, n, WIDTH'(req_ready), WIDTH'(v.rdy));
        chk({nm, ".bram_ena"}, n, WIDTH'(bram_ena), WIDTH'(v.ena));
        chk({nm, ".bram_enb"}, n, WIDTH'(bram_enb), WIDTH'(v.enb));
        chk({nm, ".bram_wea"}, n, WIDTH'(bram_wea), WIDTH'(v.wea));
        chk({nm, ".resp_valid"}, n, WIDTH'(resp_valid), WIDTH'(v.rv));
        if (v.ena) chk({nm, ".addra"}, n, WIDTH'(bram_addra), WIDTH'(v.rdy[1] ? v.a1 : v.a0));
        if (v.ena) chk({nm, ".dia"}, n, bram_dia, v.d0);
        if (v.enb) chk({nm, ".addrb"}, n, WIDTH'(bram_addrb), WIDTH'(v.rdy[1] ? v.a1 : v.a0));
        if (v.rv[0]) chk({nm, ".resp_data0"}, n, resp_data[WIDTH-1:0], v.e0);
        if (v.rv[1]) chk({nm, ".resp_data1"}, n, resp_data[2*WIDTH-1:WIDTH], v.e1);
    endtask

    task automatic check_reset_outputs(input int n);
        chk("rst.req_ready", n, WIDTH'(req_ready), Z);
        chk("rst.bram_ena", n, WIDTH'(bram_ena), Z);
        chk("rst.bram_enb", n, WIDTH'(bram_enb), Z);
        chk("rst.bram_wea", n, WIDTH'(bram_wea), Z);
        chk("rst.resp_valid", n, WIDTH'(resp_valid), Z);
    endtask

    vec_t tbl [27];
    vec_t seq_bp [12];
    vec_t idle;

    initial begin
        idle = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0, Z, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, Z, Z);

        // Basic write/read, partial write, read interleave, write/read interleave, tie-break after idle.
        tbl[0]  = mk(2'b01, 2'b01, 2'b00, 7'd5, 7'd0, FULL,   ONES, 2'b01, 1'b1, 1'b0, FULL,   2'b00, Z, Z);
        tbl[1]  = mk(2'b01, 2'b00, 2'b00, 7'd5, 7'd0, 16'h0,  Z,    2'b01, 1'b0, 1'b1, 16'h0,  2'b00, Z, Z);
        tbl[2]  = mk(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b00, Z, Z);
        tbl[3]  = mk(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b01, ONES, Z);
        tbl[4]  = mk(2'b01, 2'b01, 2'b01, 7'd5, 7'd0, 16'h1,  DAB,  2'b01, 1'b1, 1'b0, 16'h1,  2'b01, ONES, Z);
        tbl[5]  = mk(2'b01, 2'b00, 2'b01, 7'd5, 7'd0, 16'h0,  Z,    2'b01, 1'b0, 1'b1, 16'h0,  2'b00, Z, Z);
        tbl[6]  = mk(2'b00, 2'b00, 2'b01, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b00, Z, Z);
        tbl[7]  = mk(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b01, ABW, Z);
        tbl[8]  = mk(2'b11, 2'b00, 2'b11, 7'd5, 7'd5, 16'h0,  Z,    2'b10, 1'b0, 1'b1, 16'h0,  2'b01, ABW, Z);
        tbl[9]  = mk(2'b11, 2'b00, 2'b11, 7'd5, 7'd5, 16'h0,  Z,    2'b01, 1'b0, 1'b1, 16'h0,  2'b00, Z, Z);
        tbl[10] = mk(2'b11, 2'b00, 2'b11, 7'd5, 7'd5, 16'h0,  Z,    2'b10, 1'b0, 1'b1, 16'h0,  2'b10, Z, ABW);
        tbl[11] = mk(2'b11, 2'b00, 2'b11, 7'd5, 7'd5, 16'h0,  Z,    2'b01, 1'b0, 1'b1, 16'h0,  2'b01, ABW, Z);
        tbl[12] = mk(2'b11, 2'b00, 2'b11, 7'd5, 7'd5, 16'h0,  Z,    2'b10, 1'b0, 1'b1, 16'h0,  2'b10, Z, ABW);
        tbl[13] = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b01, ABW, Z);
        tbl[14] = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b10, Z, ABW);
        tbl[15] = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b00, Z, Z);
        tbl[16] = mk(2'b11, 2'b01, 2'b11, 7'd6, 7'd5, FULL,   XD,   2'b01, 1'b1, 1'b0, FULL,   2'b00, Z, Z);
        tbl[17] = mk(2'b11, 2'b01, 2'b11, 7'd6, 7'd5, FULL,   XD,   2'b10, 1'b0, 1'b1, 16'h0,  2'b00, Z, Z);
        tbl[18] = mk(2'b11, 2'b01, 2'b11, 7'd6, 7'd5, FULL,   XD,   2'b01, 1'b1, 1'b0, FULL,   2'b00, Z, Z);
        tbl[19] = mk(2'b11, 2'b01, 2'b11, 7'd6, 7'd5, FULL,   XD,   2'b10, 1'b0, 1'b1, 16'h0,  2'b10, Z, ABW);
        tbl[20] = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b00, Z, Z);
        tbl[21] = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b10, Z, ABW);
        tbl[22] = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b00, Z, Z);
        tbl[23] = mk(2'b11, 2'b11, 2'b11, 7'd7, 7'd7, FULL,   XD,   2'b01, 1'b1, 1'b0, FULL,   2'b00, Z, Z);
        tbl[24] = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b00, Z, Z);
        tbl[25] = mk(2'b00, 2'b00, 2'b11, 7'd0, 7'd0, 16'h0,  Z,    2'b00, 1'b0, 1'b0, 16'h0,  2'b00, Z, Z);
        tbl[26] = mk(2'b11, 2'b11, 2'b11, 7'd7, 7'd7, FULL,   XD,   2'b10, 1'b1, 1'b0, FULL,   2'b00, Z, Z);

        // Response back-pressure: slot held five cycles while a new read waits.
        seq_bp[0] = mk(2'b01, 2'b00, 2'b00, 7'd6, 7'd0, 16'h0, Z, 2'b01, 1'b0, 1'b1, 16'h0, 2'b00, Z, Z);
        seq_bp[1] = mk(2'b01, 2'b00, 2'b00, 7'd5, 7'd0, 16'h0, Z, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, Z, Z);
        for (int i = 2; i < 7; i++)
            seq_bp[i] = mk(2'b01, 2'b00, 2'b00, 7'd5, 7'd0, 16'h0, Z, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, XD, Z);
        seq_bp[7]  = mk(2'b01, 2'b00, 2'b01, 7'd5, 7'd0, 16'h0, Z, 2'b01, 1'b0, 1'b1, 16'h0, 2'b01, XD, Z);
        seq_bp[8]  = mk(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 16'h0, Z, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, Z, Z);
        seq_bp[9]  = mk(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 16'h0, Z, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, ABW, Z);
        seq_bp[10] = mk(2'b00, 2'b00, 2'b01, 7'd0, 7'd0, 16'h0, Z, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, ABW, Z);
        seq_bp[11] = mk(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 16'h0, Z, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, Z, Z);

        // Reset with both requesters asking to write.
        rst_n = 1'b0;
        drive(mk(2'b11, 2'b11, 2'b11, 7'd1, 7'd2, FULL, XD, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, Z, Z));
        #12;
        check_reset_outputs(0);
        chk("rst.resp_data", 0, resp_data[WIDTH-1:0] | resp_data[2*WIDTH-1:WIDTH], Z);
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle);

        for (int i = 0; i < 27; i++) begin
            cyc(tbl[i]);
            check_vec("tbl", i, tbl[i]);
        end

        for (int i = 0; i < 12; i++) begin
            cyc(seq_bp[i]);
            check_vec("bp", i, seq_bp[i]);
        end

        // Reset one cycle after a read is accepted: the read must vanish and r0 wins next.
        cyc(mk(2'b01, 2'b00, 2'b11, 7'd5, 7'd0, 16'h0, Z, 2'b01, 1'b0, 1'b1, 16'h0, 2'b00, Z, Z));
        check_vec("rstrd", 0, mk(2'b01, 2'b00, 2'b11, 7'd5, 7'd0, 16'h0, Z, 2'b01, 1'b0, 1'b1, 16'h0, 2'b00, Z, Z));
        @(posedge clk);
        #1 rst_n = 1'b0;
        drive(mk(2'b11, 2'b00, 2'b11, 7'd5, 7'd5, 16'h0, Z, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, Z, Z));
        #1 check_reset_outputs(1);
        @(posedge clk);
        #1 check_reset_outputs(2);
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle);
        for (int i = 0; i < 3; i++) begin
            cyc(idle);
            check_vec("rstidle", i, idle);
        end
        cyc(mk(2'b11, 2'b11, 2'b11, 7'd7, 7'd7, FULL, XD, 2'b01, 1'b1, 1'b0, FULL, 2'b00, Z, Z));
        check_vec("rstgrant", 0, mk(2'b11, 2'b11, 2'b11, 7'd7, 7'd7, FULL, XD, 2'b01, 1'b1, 1'b0, FULL, 2'b00, Z, Z));

        cyc(idle);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one simple-dual-port block RAM between NREQ requesters, e.g. instruction fetch and load/store.
- The RAM has a byte-masked write port A and a read port B with 1-cycle registered read. Its data is unchanged when its enables are low.
- The block arbitrates read and write requests round-robin, issues at most one RAM access per cycle, and returns read data through a registered per-requester response slot with valid/ready.

Parameters:
- WIDTH, 128: RAM word width in bits.
- DEPTH, 128: RAM word count.
- ADDRW, $clog2(DEPTH): word address width.
- MASKW, WIDTH/8: byte-mask width.
- NREQ, 2: number of requesters, legal 2..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle (combinational).
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDRW  word address, requester i at [i*ADDRW +: ADDRW].
- req_wmask  in  NREQ*MASKW  byte write enables.
- req_wdata  in  NREQ*WIDTH  write data.
- resp_valid  out  NREQ  read data valid.
- resp_ready  in  NREQ  requester consumes response.
- resp_data  out  NREQ*WIDTH  read data, registered.
- bram_ena  out  1  RAM write-port enable.
- bram_wea  out  MASKW  RAM byte write enables.
- bram_addra  out  ADDRW  RAM write address.
- bram_dia  out  WIDTH  RAM write data.
- bram_enb  out  1  RAM read-port enable.
- bram_addrb  out  ADDRW  RAM read address.
- bram_dob  in  WIDTH  RAM read data, valid the cycle after bram_enb.

Behaviour:
- Eligibility of requester i:
  - req_valid[i] is high, and
  - for writes: always eligible.
  - for reads: pending[i] = 0 and (resp_valid[i] = 0 or resp_ready[i] = 1).
- Arbitration:
  - One grant per cycle, round-robin.
  - Search starts at last_grant+1 modulo NREQ; the first eligible requester wins.
  - last_grant updates only on a grant.
  - Reset value of last_grant is NREQ-1, so requester 0 wins first.
- Handshake:
  - req_ready = one-hot grant.
  - Transfer occurs on req_valid & req_ready.
  - Requesters hold their request fields stable until accepted.
  - req_ready may depend combinationally on req_valid and resp_ready. It never depends on bram_dob.
- Write grant, same cycle:
  - bram_ena = 1, bram_wea = mask, bram_addra = addr, bram_dia = wdata.
  - bram_enb = 0.
  - No response is produced.
  - wmask = 0 is still accepted and is a no-op.
- Read grant in cycle T:
  - bram_enb = 1, bram_addrb = addr, bram_ena = 0, bram_wea = 0. Set pending[i].
  - At the T+1 edge: resp_data[i] <= bram_dob, resp_valid[i] <= 1, pending[i] <= 0.
  - Read latency: request acceptance to resp_valid is 2 cycles.
- Response slot:
  - resp_valid[i] clears on resp_valid & resp_ready unless a new capture occurs the same edge; capture wins.
  - resp_data is held stable while resp_valid = 1 and resp_ready = 0.
- Per-requester throughput:
  - Reads: one per 2 cycles.
  - Interleaved requesters reach one RAM access per cycle.
  - Writes: one per cycle.
- Ordering:
  - A write accepted in cycle T is visible to any read accepted in T+1 or later.
  - No same-cycle read/write collision exists, since only one grant is issued.
- Idle outputs:
  - bram_ena = 0, bram_enb = 0, bram_wea = 0.
  - Address and data outputs are don't-care but must be driven (drive from requester 0).
- Reset (rst_n low, asynchronous):
  - resp_valid = 0, pending = 0, last_grant = NREQ-1, resp_data = 0.
  - req_ready = 0, bram_ena = 0, bram_enb = 0, bram_wea = 0 while rst_n is low.
- Reset mid-read: an in-flight read is discarded and no response appears after release. RAM contents are untouched.

Test Plan:
- After reset: r0 write addr 5, mask all-ones, data 0x1111…; next cycle r0 read addr 5 -> bram_enb cycle T; resp_valid[0] high at T+2 with data 0x1111…
- Partial write: mask 0x0001, data 0xAB to addr 5 holding 0x1111… -> read returns 0x1111…11AB.
- r0 and r1 both hold reads every cycle -> grants alternate 0,1,0,1 and each resp_valid is high every other cycle with the correct data. With r0 issuing continuous writes instead, grants still alternate.
- r0 has resp_valid = 1 and resp_ready held 0 for 5 cycles, with a new r0 read pending -> req_ready[0] stays 0 and resp_data[0] is unchanged. Raising resp_ready grants the read in that cycle, and new data arrives 2 cycles later.
- Read accepted, then rst_n pulsed low in T+1 -> resp_valid stays 0 after release, and the next grant goes to r0.
- Idle cycles with no req_valid -> bram_ena = 0, bram_enb = 0, bram_wea = 0, and last_grant is unchanged (verified by next tie-break order).
